// File: rtl/quant_stream_packer.sv
// Purpose: buffers quantized INT8 vectors and emits them as one AXI4-Stream frame with TLAST, plus status.
// Latency: a vector accepted in cycle N is presented on m_axis_tvalid in cycle N+1 when the FIFO was empty.
// Backpressure: m_axis_tready stalls are absorbed by the FIFO; upstream cannot stall, so excess vectors are dropped and flagged.
module quant_stream_packer #(
  parameter int ARRAY_COLS = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            frame_len,
  input  logic                            abort,
  input  logic [OUT_WIDTH*ARRAY_COLS-1:0] quant_out_packed,
  input  logic                            quant_valid,
  input  logic                            any_saturated,
  output logic [OUT_WIDTH*ARRAY_COLS-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic                            overrun,
  output logic [LEN_WIDTH-1:0]            sat_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int DW    = OUT_WIDTH * ARRAY_COLS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;
  logic [LEN_WIDTH-1:0] frame_len_q;
  logic [LEN_WIDTH-1:0] in_cnt;
  logic [LEN_WIDTH-1:0] out_cnt;
  logic [LEN_WIDTH-1:0] sat_cnt_q;
  logic                 overflow_q, overrun_q, done_q, done_d;

  logic run, fifo_full, fifo_empty, pop, room, want, push;
  logic drop_full, drop_idle, last_beat, last_hs;
  logic start_ok, start_frame, start_zero;

  // Handshake and acceptance qualifiers shared by the FSM, FIFO and counters.
  always_comb begin
    run         = (state_q == RUN);
    fifo_full   = (level == LVL_W'(FIFO_DEPTH));
    fifo_empty  = (level == '0);
    pop         = !fifo_empty && m_axis_tready;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    room        = !fifo_full || pop;
    want        = run && quant_valid && (in_cnt < frame_len_q);
    push        = want && room && !abort;
    drop_full   = want && !room && !abort;
    drop_idle   = quant_valid && (!run || (in_cnt == frame_len_q)) && !abort;
    last_beat   = run && (out_cnt == (frame_len_q - LEN_WIDTH'(1)));
    last_hs     = pop && last_beat;
    // start is only honoured from IDLE and always loses to abort.
    start_ok    = start && !abort && !run;
    start_frame = start_ok && (frame_len != '0);
    start_zero  = start_ok && (frame_len == '0);
  end

  // Next-state and done-pulse decode; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_frame) state_d = RUN;
        if (start_zero)  done_d  = 1'b1;
      end
      RUN: begin
        if (last_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // FIFO payload storage; contents are don't-care while the entry is not valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= quant_out_packed;
  end

  // FIFO pointers and occupancy; abort discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame length latch plus input/output beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_len_q <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
    end else if (start_frame) begin
      frame_len_q <= frame_len;
      in_cnt      <= '0;
      out_cnt     <= '0;
    end else if (!abort) begin
      if (push) in_cnt  <= in_cnt + LEN_WIDTH'(1);
      if (pop)  out_cnt <= out_cnt + LEN_WIDTH'(1);
    end
  end

  // Saturated-vector counter, stops at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (start_ok) begin
      sat_cnt_q <= '0;
    end else if (push && any_saturated && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + LEN_WIDTH'(1);
    end
  end

  // Sticky drop flags; a vector arriving with start is still an IDLE drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (start_ok) begin
      overflow_q <= 1'b0;
      overrun_q  <= quant_valid;
    end else begin
      if (drop_full) overflow_q <= 1'b1;
      if (drop_idle) overrun_q  <= 1'b1;
    end
  end

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr];
  assign m_axis_tlast  = !fifo_empty && last_beat;
  assign busy          = run;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign overrun       = overrun_q;
  assign sat_count     = sat_cnt_q;
  assign fifo_level    = level;

endmodule
